// File: rtl/divider_unit.sv
// Sequential binary32 divider: restoring mantissa division, one quotient bit per clock,
// truncated result. Define DIVIDERUNIT_SPECIAL_EN to add NaN/inf/zero/overflow handling.
module divider_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic [31:0] dataR,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM} state_t;

    state_t      r_state;
    logic        r_sign;
    logic [7:0]  r_exp_a;
    logic [7:0]  r_exp_b;
    logic [23:0] r_mb;
    logic [24:0] r_rem;
    logic [24:0] r_q;
    logic [4:0]  r_cnt;

    // The remainder register holds the value being compared this cycle; it starts as mA
    // so 25 iterations yield floor(mA * 2^24 / mB).
    logic [25:0] w_diff;
    logic        w_ge;
    logic [24:0] w_rem_keep;
    logic [22:0] w_mant;

    assign w_diff     = {1'b0, r_rem} - {2'b00, r_mb};
    assign w_ge       = ~w_diff[25];
    assign w_rem_keep = w_ge ? w_diff[24:0] : r_rem;
    assign w_mant     = r_q[24] ? r_q[23:1] : r_q[22:0];

`ifdef DIVIDERUNIT_SPECIAL_EN
    logic               r_special;
    logic [31:0]        r_special_val;
    logic signed [9:0]  w_exp;
    logic               w_sign_in;
    logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic               w_is_special;
    logic [31:0]        w_special_val;

    assign w_exp = $signed({2'b00, r_exp_a}) - $signed({2'b00, r_exp_b})
                 + (r_q[24] ? 10'sd127 : 10'sd126);

    assign w_sign_in = dataA[31] ^ dataB[31];
    assign w_a_zero  = ~|dataA[30:23];
    assign w_b_zero  = ~|dataB[30:23];
    assign w_a_inf   = (&dataA[30:23]) & ~|dataA[22:0];
    assign w_b_inf   = (&dataB[30:23]) & ~|dataB[22:0];
    assign w_a_nan   = (&dataA[30:23]) &  |dataA[22:0];
    assign w_b_nan   = (&dataB[30:23]) &  |dataB[22:0];

    always_comb begin
        w_is_special  = 1'b1;
        w_special_val = 32'h7FC0_0000;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
            w_special_val = 32'h7FC0_0000;
        else if (w_a_inf || w_b_zero)
            w_special_val = {w_sign_in, 31'h7F80_0000};
        else if (w_a_zero || w_b_inf)
            w_special_val = {w_sign_in, 31'h0};
        else
            w_is_special = 1'b0;
    end
`else
    logic [7:0] w_exp;

    assign w_exp = r_exp_a - r_exp_b + (r_q[24] ? 8'd127 : 8'd126);
`endif

    // NOTE: every datapath register is cleared by the async reset so an aborted
    // division leaves no stale quotient, remainder or counter behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sign  <= 1'b0;
            r_exp_a <= '0;
            r_exp_b <= '0;
            r_mb    <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            dataR   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef DIVIDERUNIT_SPECIAL_EN
            r_special     <= 1'b0;
            r_special_val <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign  <= dataA[31] ^ dataB[31];
                        r_exp_a <= dataA[30:23];
                        r_exp_b <= dataB[30:23];
                        r_mb    <= {1'b1, dataB[22:0]};
                        r_rem   <= {2'b01, dataA[22:0]};
                        r_q     <= '0;
                        r_cnt   <= 5'd24;
                        busy    <= 1'b1;
`ifdef DIVIDERUNIT_SPECIAL_EN
                        r_special     <= w_is_special;
                        r_special_val <= w_special_val;
                        r_state       <= w_is_special ? NORM : DIVIDE;
`else
                        r_state <= DIVIDE;
`endif
                    end
                end
                DIVIDE: begin
                    r_rem <= w_rem_keep << 1;
                    r_q   <= {r_q[23:0], w_ge};
                    if (r_cnt == 5'd0) r_state <= NORM;
                    else               r_cnt   <= r_cnt - 5'd1;
                end
                NORM: begin
`ifdef DIVIDERUNIT_SPECIAL_EN
                    if (r_special)             dataR <= r_special_val;
                    else if (w_exp >= 10'sd255) dataR <= {r_sign, 31'h7F80_0000};
                    else if (w_exp <= 10'sd0)   dataR <= {r_sign, 31'h0};
                    else                        dataR <= {r_sign, w_exp[7:0], w_mant};
`else
                    dataR <= {r_sign, w_exp, w_mant};
`endif
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// Directed-vector bench for divider_unit: latency, truncation, handshake, reset abort
// and the build-dependent special-operand behaviour.
module tb_divider_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] dataR;
    logic        busy;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] res;
    int          lat;
    int          nbusy;

    divider_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .dataA (dataA),
        .dataB (dataB),
        .dataR (dataR),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Issue one operation; lat = edges from E0 to the edge that raised done (-1 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dataA = a;
        dataB = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dataA = 32'hDEAD_BEEF;
        dataB = 32'h1234_5678;
        lat   = -1;
        nbusy = 0;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
        res = dataR;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        dataA = '0;
        dataB = '0;
        #12;
        n_total++;
        if (dataR !== 32'h0) $display("FAIL reset_dataR got %h want 00000000", dataR);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else n_pass++;
        n_total++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(32'h40C0_0000, 32'h4000_0000);
        n_total++;
        if (res !== 32'h4040_0000) $display("FAIL div_6_2 got %h want 40400000", res);
        else n_pass++;
        n_total++;
        if (lat !== 26) $display("FAIL div_6_2_latency got %0d want 26", lat);
        else n_pass++;
        n_total++;
        if (nbusy !== 26) $display("FAIL div_6_2_busy_cycles got %0d want 26", nbusy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done, busy);
        else n_pass++;

        run_op(32'h3F80_0000, 32'h4040_0000);
        n_total++;
        if (res !== 32'h3EAA_AAAA) $display("FAIL div_1_3_trunc got %h want 3eaaaaaa", res);
        else n_pass++;

        run_op(32'hC0C0_0000, 32'h4000_0000);
        n_total++;
        if (res !== 32'hC040_0000) $display("FAIL div_m6_2 got %h want c0400000", res);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int ndone;
        @(negedge clk);
        dataA = 32'h40C0_0000;
        dataB = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dataA = 32'h3F80_0000;
        dataB = 32'h4040_0000;
        lat   = -1;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            start = (k == 4);
            @(negedge clk);
        end
        start = 1'b0;
        n_total++;
        if (dataR !== 32'h4040_0000 || lat !== 26)
            $display("FAIL start_ignored_result got %h lat %0d want 40400000 lat 26", dataR, lat);
        else n_pass++;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_total++;
        if (ndone !== 0) $display("FAIL start_not_queued got %0d done pulses want 0", ndone);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL idle_after_ignore got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res1;
        int          lat1;
        @(negedge clk);
        dataA = 32'h40C0_0000;
        dataB = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat1 = -1;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                lat1 = k;
                break;
            end
            @(negedge clk);
        end
        res1  = dataR;
        dataA = 32'h3F80_0000;
        dataB = 32'h4040_0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (res1 !== 32'h4040_0000 || lat1 !== 26)
            $display("FAIL b2b_first got %h lat %0d want 40400000 lat 26", res1, lat1);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL b2b_accept_E27 got busy=%b want 1", busy);
        else n_pass++;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        n_total++;
        if (dataR !== 32'h3EAA_AAAA) $display("FAIL b2b_second got %h want 3eaaaaaa", dataR);
        else n_pass++;
        n_total++;
        if (lat !== 26) $display("FAIL b2b_second_latency got %0d want 26", lat);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ndone;
        @(negedge clk);
        dataA = 32'h40C0_0000;
        dataB = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if (dataR !== 32'h0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_mid_async got dataR=%h busy=%b done=%b want 0 0 0", dataR, busy, done);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        n_total++;
        if (ndone !== 0) $display("FAIL reset_mid_discard got %0d active cycles want 0", ndone);
        else n_pass++;
        run_op(32'h40C0_0000, 32'h4000_0000);
        n_total++;
        if (res !== 32'h4040_0000 || lat !== 26)
            $display("FAIL reset_mid_rerun got %h lat %0d want 40400000 lat 26", res, lat);
        else n_pass++;
    endtask

`ifdef DIVIDERUNIT_SPECIAL_EN
    task automatic test_special();
        run_op(32'h3F80_0000, 32'h0000_0000);
        n_total++;
        if (res !== 32'h7F80_0000 || lat !== 1)
            $display("FAIL special_1_0 got %h lat %0d want 7f800000 lat 1", res, lat);
        else n_pass++;
        run_op(32'h0000_0000, 32'h0000_0000);
        n_total++;
        if (res !== 32'h7FC0_0000) $display("FAIL special_0_0 got %h want 7fc00000", res);
        else n_pass++;
        run_op(32'h7F7F_FFFF, 32'h0080_0000);
        n_total++;
        if (res !== 32'h7F80_0000 || lat !== 26)
            $display("FAIL special_overflow got %h lat %0d want 7f800000 lat 26", res, lat);
        else n_pass++;
    endtask
`else
    task automatic test_no_special();
        run_op(32'h3F80_0000, 32'h0000_0000);
        n_total++;
        if (res !== 32'h7F00_0000) $display("FAIL nospecial_1_0 got %h want 7f000000", res);
        else n_pass++;
        n_total++;
        if (lat !== 26) $display("FAIL nospecial_1_0_latency got %0d want 26", lat);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
`ifdef DIVIDERUNIT_SPECIAL_EN
        test_special();
`else
        test_no_special();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
